// File: rtl/load_store_seq_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states and beat count.
package load_store_seq_pkg;

   localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
   localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
   localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
   localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'b00,
      LSU_ACCESS = 2'b01,
      LSU_DONE   = 2'b10
   } lsu_state_t;

   function automatic logic [2:0] lsu_beats(input logic [1:0] size);
      case (size)
         LSU_SIZE_BYTE: lsu_beats = 3'd1;
         LSU_SIZE_HALF: lsu_beats = 3'd2;
         default:       lsu_beats = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/load_store_seq_extend.sv
// Combinational sign/zero extension of the captured load bytes to a full register word.
module lsu_extend
   import load_store_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] bytes,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = bytes;
      case (size)
         LSU_SIZE_BYTE: result = {{(DATA_W-8){sign_ext & bytes[7]}}, bytes[7:0]};
         LSU_SIZE_HALF: result = {{(DATA_W-16){sign_ext & bytes[15]}}, bytes[15:0]};
         default:       result = bytes;
      endcase
   end

endmodule

// File: rtl/load_store_seq.sv
// Byte-serial load/store sequencer between the pipeline and a byte-wide data memory.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module load_store_seq
   import load_store_seq_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_W  = 8
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              req_valid_in,
   output logic              req_ready_out,
   input  logic              req_we_in,
   input  logic [1:0]        req_size_in,
   input  logic              req_signed_in,
   input  logic [ADDR_W-1:0] req_addr_in,
   input  logic [DATA_W-1:0] req_wdata_in,
   output logic              rsp_valid_out,
   output logic [DATA_W-1:0] rsp_rdata_out,
   output logic              rsp_err_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_we_out,
   output logic [MEM_W-1:0]  mem_wd_out,
   input  logic [MEM_W-1:0]  mem_rd_in
);

   lsu_state_t        state_q, state_d;
   logic              accept, req_err, last_beat;
   logic [1:0]        beat_q, size_q;
   logic              we_q, signed_q, err_q;
   logic [ADDR_W-1:0] base_q, last_addr_q, beat_addr;
   logic [DATA_W-1:0] wdata_q, rdata_q, ext_data;

   assign req_ready_out = (state_q == LSU_IDLE);
   assign accept        = req_valid_in & req_ready_out;
   assign beat_addr     = base_q + ADDR_W'(beat_q);
   assign last_beat     = ({1'b0, beat_q} == (lsu_beats(size_q) - 3'd1));
   assign mem_addr_out  = (state_q == LSU_ACCESS) ? beat_addr : last_addr_q;

   // Requests flagged here skip the memory entirely and answer with an error.
   always_comb begin
      req_err = (req_size_in == LSU_SIZE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
      if (req_size_in == LSU_SIZE_HALF && req_addr_in[0])
         req_err = 1'b1;
      if (req_size_in == LSU_SIZE_WORD && (req_addr_in[1:0] != 2'b00))
         req_err = 1'b1;
`endif
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in)
         state_q <= LSU_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE:   if (accept) state_d = req_err ? LSU_DONE : LSU_ACCESS;
         LSU_ACCESS: if (last_beat) state_d = LSU_DONE;
         LSU_DONE:   state_d = LSU_IDLE;
         default:    state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         base_q      <= '0;
         last_addr_q <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         signed_q    <= 1'b0;
         err_q       <= 1'b0;
         beat_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
      end else if (accept) begin
         base_q   <= req_addr_in;
         size_q   <= req_size_in;
         we_q     <= req_we_in;
         signed_q <= req_signed_in;
         err_q    <= req_err;
         wdata_q  <= req_wdata_in;
         beat_q   <= '0;
         rdata_q  <= '0;
      end else if (state_q == LSU_ACCESS) begin
         beat_q      <= beat_q + 2'd1;
         last_addr_q <= beat_addr;
         if (!we_q)
            rdata_q[int'(beat_q)*MEM_W +: MEM_W] <= mem_rd_in;
      end
   end

   always_comb begin
      mem_we_out    = 1'b0;
      mem_wd_out    = '0;
      rsp_valid_out = 1'b0;
      rsp_rdata_out = '0;
      rsp_err_out   = 1'b0;
      case (state_q)
         LSU_ACCESS: begin
            mem_we_out = we_q;
            if (we_q)
               mem_wd_out = wdata_q[int'(beat_q)*MEM_W +: MEM_W];
         end
         LSU_DONE: begin
            rsp_valid_out = 1'b1;
            rsp_err_out   = err_q;
            if (!we_q && !err_q)
               rsp_rdata_out = ext_data;
         end
         default: ;
      endcase
   end

   lsu_extend #(.DATA_W(DATA_W)) u_extend (
      .bytes    (rdata_q),
      .size     (size_q),
      .sign_ext (signed_q),
      .result   (ext_data)
   );

endmodule

// File: tb/tb_load_store_seq.sv
// Directed self-checking bench for load_store_seq with a 256-byte memory model.
// Expectations for misaligned accesses follow LSU_ALIGN_CHECK_EN when it is defined.
module tb_load_store_seq;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req_valid_in, req_ready_out, req_we_in, req_signed_in;
   logic [1:0]  req_size_in;
   logic [31:0] req_addr_in, req_wdata_in;
   logic        rsp_valid_out, rsp_err_out;
   logic [31:0] rsp_rdata_out, mem_addr_out;
   logic        mem_we_out;
   logic [7:0]  mem_wd_out, mem_rd_in;

   logic [7:0]  mem [0:255];
   int          checks = 0;
   int          passes = 0;
   int          lat, nlog, weCnt;
   logic [31:0] rspData;
   logic        rspErr, rspSeen;
   logic [31:0] addrLog [0:7];
   logic [7:0]  wdLog [0:7];

   always #5 clk_in = ~clk_in;

   assign mem_rd_in = mem[mem_addr_out[7:0]];

   // The memory commits a store byte at the rising edge where the sequencer drives it.
   always @(posedge clk_in) begin
      if (mem_we_out)
         mem[mem_addr_out[7:0]] = mem_wd_out;
   end

   load_store_seq dut (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .req_valid_in  (req_valid_in),
      .req_ready_out (req_ready_out),
      .req_we_in     (req_we_in),
      .req_size_in   (req_size_in),
      .req_signed_in (req_signed_in),
      .req_addr_in   (req_addr_in),
      .req_wdata_in  (req_wdata_in),
      .rsp_valid_out (rsp_valid_out),
      .rsp_rdata_out (rsp_rdata_out),
      .rsp_err_out   (rsp_err_out),
      .mem_addr_out  (mem_addr_out),
      .mem_we_out    (mem_we_out),
      .mem_wd_out    (mem_wd_out),
      .mem_rd_in     (mem_rd_in)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      else
         passes++;
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_valid_in  = 1'b1;
      req_we_in     = we;
      req_size_in   = size;
      req_signed_in = sgn;
      req_addr_in   = addr;
      req_wdata_in  = wdata;
   endtask

   // Issues one request from a falling edge while idle and logs every cycle until the response.
   task automatic runReq(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(we, size, sgn, addr, wdata);
      @(posedge clk_in);
      lat = 0; nlog = 0; weCnt = 0; rspData = '0; rspErr = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_in);
         req_valid_in = 1'b0;
         if (rsp_valid_out) begin
            lat     = c;
            rspData = rsp_rdata_out;
            rspErr  = rsp_err_out;
            break;
         end
         if (nlog < 8) begin
            addrLog[nlog] = mem_addr_out;
            wdLog[nlog]   = mem_wd_out;
         end
         nlog++;
         if (mem_we_out) weCnt++;
      end
      if (lat == 0) checkOutput("rsp_timeout", 32'd0, 32'd1);
      @(negedge clk_in);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h80; mem[8'h11] = 8'h7F; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
      mem[8'h14] = 8'h5A;
      mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h23] = 8'h44;
      mem[8'h42] = 8'h55; mem[8'h43] = 8'h66;
      mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
      req_valid_in = 1'b0; req_we_in = 1'b0; req_size_in = 2'b00; req_signed_in = 1'b0;
      req_addr_in = '0; req_wdata_in = '0;
      reset_in = 1'b1;
      #1 reset_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      checkOutput("rst_ready", 32'(req_ready_out), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
      checkOutput("rst_rdata", rsp_rdata_out, 32'd0);
      checkOutput("rst_err", 32'(rsp_err_out), 32'd0);
      checkOutput("rst_mem_addr", mem_addr_out, 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we_out), 32'd0);
      checkOutput("rst_mem_wd", 32'(mem_wd_out), 32'd0);
      reset_in = 1'b1;
      @(negedge clk_in);

      runReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checkOutput("wld_latency", 32'(lat), 32'd5);
      checkOutput("wld_beats", 32'(nlog), 32'd4);
      checkOutput("wld_addr0", addrLog[0], 32'h10);
      checkOutput("wld_addr3", addrLog[3], 32'h13);
      checkOutput("wld_we", 32'(weCnt), 32'd0);
      checkOutput("wld_rdata", rspData, 32'h12347F80);
      checkOutput("wld_err", 32'(rspErr), 32'd0);
      checkOutput("idle_addr_hold", mem_addr_out, 32'h13);
      checkOutput("idle_ready", 32'(req_ready_out), 32'd1);

      runReq(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
      checkOutput("bld_s_latency", 32'(lat), 32'd2);
      checkOutput("bld_s_rdata", rspData, 32'hFFFFFF80);
      runReq(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      checkOutput("bld_u_rdata", rspData, 32'h00000080);
      runReq(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
      checkOutput("hld_mis_err", 32'(rspErr), 32'd1);
      checkOutput("hld_mis_rdata", rspData, 32'd0);
`else
      checkOutput("hld_u_latency", 32'(lat), 32'd3);
      checkOutput("hld_u_rdata", rspData, 32'h0000347F);
`endif

      runReq(1'b1, 2'b01, 1'b0, 32'h20, 32'hCAFEBEEF);
      checkOutput("hst_latency", 32'(lat), 32'd3);
      checkOutput("hst_we_cycles", 32'(weCnt), 32'd2);
      checkOutput("hst_wd0", 32'(wdLog[0]), 32'hEF);
      checkOutput("hst_wd1", 32'(wdLog[1]), 32'hBE);
      checkOutput("hst_rdata", rspData, 32'd0);
      checkOutput("hst_idle_wd", 32'(mem_wd_out), 32'd0);
      checkOutput("hst_byte22", 32'(mem[8'h22]), 32'h33);
      runReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checkOutput("hst_reload", rspData, 32'h4433BEEF);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'hAABBCCDD);
      @(posedge clk_in);
      @(negedge clk_in);
      req_valid_in = 1'b0;
      checkOutput("rmid_beat0_we", 32'(mem_we_out), 32'd1);
      @(negedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b0;
      #1;
      checkOutput("rmid_we_async", 32'(mem_we_out), 32'd0);
      rspSeen = rsp_valid_out;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         rspSeen = rspSeen | rsp_valid_out;
      end
      reset_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 rspSeen = rspSeen | rsp_valid_out;
         @(negedge clk_in);
      end
      checkOutput("rmid_no_rsp", 32'(rspSeen), 32'd0);
      checkOutput("rmid_ready", 32'(req_ready_out), 32'd1);
      checkOutput("rmid_m40", 32'(mem[8'h40]), 32'hDD);
      checkOutput("rmid_m41", 32'(mem[8'h41]), 32'hCC);
      checkOutput("rmid_m42", 32'(mem[8'h42]), 32'h55);
      checkOutput("rmid_m43", 32'(mem[8'h43]), 32'h66);

      applyStimulus(1'b1, 2'b11, 1'b0, 32'h30, 32'h12345678);
      @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("rsvd_rsp1", 32'(rsp_valid_out), 32'd1);
      checkOutput("rsvd_err", 32'(rsp_err_out), 32'd1);
      checkOutput("rsvd_rdata", rsp_rdata_out, 32'd0);
      checkOutput("rsvd_busy", 32'(req_ready_out), 32'd0);
      checkOutput("rsvd_no_we", 32'(mem_we_out), 32'd0);
      @(negedge clk_in);
      checkOutput("rsvd_idle_ready", 32'(req_ready_out), 32'd1);
      checkOutput("rsvd_idle_norsp", 32'(rsp_valid_out), 32'd0);
      @(negedge clk_in);
      req_valid_in = 1'b0;
      checkOutput("rsvd_rsp2", 32'(rsp_valid_out), 32'd1);
      @(negedge clk_in);
      checkOutput("rsvd_end_ready", 32'(req_ready_out), 32'd1);
      checkOutput("rsvd_end_norsp", 32'(rsp_valid_out), 32'd0);

      runReq(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
      checkOutput("wmis_err", 32'(rspErr), 32'd1);
      checkOutput("wmis_beats", 32'(nlog), 32'd0);
      checkOutput("wmis_latency", 32'(lat), 32'd1);
      runReq(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      checkOutput("wrap_err", 32'(rspErr), 32'd1);
`else
      checkOutput("wmis_err", 32'(rspErr), 32'd0);
      checkOutput("wmis_addr0", addrLog[0], 32'h11);
      checkOutput("wmis_addr3", addrLog[3], 32'h14);
      checkOutput("wmis_rdata", rspData, 32'h5A12347F);
      runReq(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      checkOutput("wrap_addr0", addrLog[0], 32'hFFFFFFFE);
      checkOutput("wrap_addr1", addrLog[1], 32'hFFFFFFFF);
      checkOutput("wrap_addr2", addrLog[2], 32'h00000000);
      checkOutput("wrap_addr3", addrLog[3], 32'h00000001);
      checkOutput("wrap_rdata", rspData, 32'hD4C3B2A1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
